// File: rtl/dmem_pkg.sv
// Shared types, defaults and the address-legality helper for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DW               = 32;
  localparam int unsigned DMEM_DEPTH_DEF   = 256;
  localparam int unsigned DMEM_LATENCY_DEF = 2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef struct packed {
    logic          wr;
    logic [DW-1:0] adr;
    logic [DW-1:0] wdata;
  } req_t;

  // Word-aligned and inside the array.
  function automatic logic adr_ok(input logic [DW-1:0] adr, input int unsigned depth);
    return (adr[1:0] == 2'b00) && ({2'b00, adr[DW-1:2]} < depth);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the CPU memory stage (master) and the responder (slave).
interface dmem_if;
  import dmem_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [DW-1:0] req_adr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_wr, req_adr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_adr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x 32; read port is a register that is zero unless a read happened.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            q
);

  logic [DW-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (en && we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          q <= '0;
    else if (en && !we)  q <= mem[idx];
    else                 q <= '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder in front of dmem_array.
// Defining DMEM_WRBUF_EN adds a one-entry posted write buffer with load forwarding.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = DMEM_DEPTH_DEF,
  parameter int unsigned LATENCY = DMEM_LATENCY_DEF
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  req_t          cap, cur;
  logic          ready_q, valid_q, err_q, err_nxt;
  logic          accept_c, cur_ok_c, access_c;
  logic [AW-1:0] cur_idx_c;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_idx;
  logic [DW-1:0] ram_wdata, ram_q;

`ifdef DMEM_WRBUF_EN
  logic          wb_full;
  logic [AW-1:0] wb_idx;
  logic [DW-1:0] wb_data, fwd_q;
  logic          buf_store_c, hit_c, drain_c;
`endif

  // In IDLE the live bus is the request; afterwards the captured copy is.
  always_comb begin
    cur = cap;
    if (state == ST_IDLE) cur = '{wr: bus.req_wr, adr: bus.req_adr, wdata: bus.req_wdata};
  end

  assign cur_ok_c  = adr_ok(cur.adr, DEPTH);
  assign cur_idx_c = cur.adr[AW+1:2];
  assign accept_c  = bus.req_valid & bus.req_ready & (state == ST_IDLE);

`ifdef DMEM_WRBUF_EN
  assign buf_store_c = (state == ST_IDLE) & cur.wr & cur_ok_c & ~wb_full;
  assign hit_c       = wb_full & ~cur.wr & cur_ok_c & (cur_idx_c == wb_idx);
  assign drain_c     = (state == ST_IDLE) & ~accept_c & wb_full;
`endif

  // Next state; access_c marks the edge entering RESP through the latency path.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
`ifdef DMEM_WRBUF_EN
          if (buf_store_c) begin
            state_nxt = ST_RESP;
          end else
`endif
          if (LATENCY == 1) begin
            state_nxt = ST_RESP;
            access_c  = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CW'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == CW'(1)) begin
          state_nxt = ST_RESP;
          access_c  = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Array port: the access itself, or a buffer drain on an otherwise unused IDLE cycle.
  always_comb begin
    ram_en    = access_c & cur_ok_c;
    ram_we    = cur.wr;
    ram_idx   = cur_idx_c;
    ram_wdata = cur.wdata;
    err_nxt   = access_c & ~cur_ok_c;
`ifdef DMEM_WRBUF_EN
    if (hit_c) ram_en = 1'b0;
    if (drain_c) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_idx   = wb_idx;
      ram_wdata = wb_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cap     <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= (state_nxt == ST_IDLE);
      valid_q <= (state_nxt == ST_RESP);
      err_q   <= err_nxt;
      if (accept_c) cap <= cur;
    end
  end

`ifdef DMEM_WRBUF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_full <= 1'b0;
      wb_idx  <= '0;
      wb_data <= '0;
      fwd_q   <= '0;
    end else begin
      if (accept_c && buf_store_c) begin
        wb_full <= 1'b1;
        wb_idx  <= cur_idx_c;
        wb_data <= cur.wdata;
      end else if (drain_c) begin
        wb_full <= 1'b0;
      end
      fwd_q <= (access_c && hit_c) ? wb_data : '0;
    end
  end

  // Loads may still be taken while a store waits for the buffer to drain.
  assign bus.req_ready = ready_q & ~(bus.req_wr & wb_full);
  assign bus.rsp_rdata = ram_q | fwd_q;
`else
  assign bus.req_ready = ready_q;
  assign bus.rsp_rdata = ram_q;
`endif
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_err   = err_q;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with LATENCY 2, 1 and 8 share clock and reset.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic        req_valid [3];
  logic        req_wr    [3];
  logic [31:0] req_adr   [3];
  logic [31:0] req_wdata [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  exp_t exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 8);
  endfunction

  function automatic int st_lat(input int d);
    int l;
    l = lat_of(d);
`ifdef DMEM_WRBUF_EN
    l = 1;
`endif
    return l;
  endfunction

  task automatic chk(input int d, input string what, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s dut%0d: got %h want %h (cycle %0d)", what, d, act, want, cyc);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_if bus ();
    exp_t   e;

    assign bus.req_valid = req_valid[g];
    assign bus.req_wr    = req_wr[g];
    assign bus.req_adr   = req_adr[g];
    assign bus.req_wdata = req_wdata[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_rdata[g]  = bus.rsp_rdata;
    assign rsp_err[g]    = bus.rsp_err;

    dmem_responder #(.DEPTH(256), .LATENCY(lat_of(g))) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Monitor: pops the scoreboard whenever this instance responds.
    always @(negedge clk) begin
      if (rst_n) begin
        if (rsp_valid[g]) begin
          if (exp_q[g].size() == 0) begin
            chk(g, "rsp_unexpected", 32'(rsp_valid[g]), 32'd0);
          end else begin
            e = exp_q[g].pop_front();
            chk(g, "rsp_rdata", rsp_rdata[g], e.rdata);
            chk(g, "rsp_err",   32'(rsp_err[g]), 32'(e.err));
            chk(g, "rsp_cycle", 32'(cyc), 32'(e.due));
          end
        end else begin
          chk(g, "idle_zero", rsp_rdata[g] | 32'(rsp_err[g]), 32'd0);
          if (exp_q[g].size() != 0 && exp_q[g][0].due < cyc) begin
            chk(g, "rsp_timeout", 32'(cyc), 32'(exp_q[g][0].due));
            void'(exp_q[g].pop_front());
          end
        end
      end
    end
  end

  // Called at a negedge; holds the request until ready, pushes the expectation, returns at the next negedge.
  task automatic issue(input int d, input logic wr, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat, output int acc);
    int   n;
    exp_t x;
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_adr[d]   = adr;
    req_wdata[d] = wd;
    n = 0;
    #1;
    while (!req_ready[d] && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready[d]) begin
      chk(d, "accept_timeout", 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b0;
      acc = -1;
      return;
    end
    x.rdata = er;
    x.err   = ee;
    x.due   = cyc + lat;
    exp_q[d].push_back(x);
    @(negedge clk);
    acc = cyc;
    req_valid[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input int d, input string tag);
    chk(d, {tag, "_ready"}, 32'(req_ready[d]), 32'd0);
    chk(d, {tag, "_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk(d, {tag, "_rdata"}, rsp_rdata[d], 32'd0);
    chk(d, {tag, "_err"},   32'(rsp_err[d]), 32'd0);
  endtask

  initial begin
    int a1, a2;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0;
      req_wr[d]    = 1'b0;
      req_adr[d]   = '0;
      req_wdata[d] = '0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) chk_reset_outputs(d, "rst");
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk(d, "ready_after_rst", 32'(req_ready[d]), 32'd1);

    // LATENCY=2: store then load, errors, top-of-array word
    issue(0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, st_lat(0), a1);
    issue(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2,         a1);
    issue(0, 1'b0, 32'h6,   32'h0,        32'h0,        1'b1, 2,         a1);
    issue(0, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 2,         a1);
    issue(0, 1'b1, 32'h3FC, 32'h5A5A0FF0, 32'h0,        1'b0, st_lat(0), a1);
    issue(0, 1'b0, 32'h3FC, 32'h0,        32'h5A5A0FF0, 1'b0, 2,         a1);
    // misaligned store must not modify word 4
    issue(0, 1'b1, 32'h11,  32'h00000BAD, 32'h0,        1'b1, 2,         a1);
    issue(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2,         a1);

    // Back-to-back with valid held high
    issue(0, 1'b1, 32'h14, 32'h11112222, 32'h0,        1'b0, st_lat(0), a1);
    issue(0, 1'b0, 32'h14, 32'h0,        32'h11112222, 1'b0, 2,         a2);
    chk(0, "b2b_gap_store", 32'(a2 - a1), 32'(st_lat(0) + 1));
    issue(0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2,         a1);
    issue(0, 1'b0, 32'h14, 32'h0,        32'h11112222, 1'b0, 2,         a2);
    chk(0, "b2b_gap_load", 32'(a2 - a1), 32'd3);

`ifndef DMEM_WRBUF_EN
    // Reset while a store sits in WAIT: no response, old contents survive
    issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 2, a1);
    idle(4);
    req_valid[0] = 1'b1;
    req_wr[0]    = 1'b1;
    req_adr[0]   = 32'h20;
    req_wdata[0] = 32'h00001234;
    #1;
    chk(0, "abort_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(0, "abort_rst");
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk(0, "ready_after_abort", 32'(req_ready[0]), 32'd1);
    issue(0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 2, a1);
`endif

`ifdef DMEM_WRBUF_EN
    // Posted store followed immediately by a forwarded load
    idle(4);
    issue(0, 1'b1, 32'h8, 32'hA5A5A5A5, 32'h0,        1'b0, 1, a1);
    issue(0, 1'b0, 32'h8, 32'h0,        32'hA5A5A5A5, 1'b0, 2, a2);
    chk(0, "wrbuf_gap", 32'(a2 - a1), 32'd2);
    idle(4);
    issue(0, 1'b0, 32'h8, 32'h0,        32'hA5A5A5A5, 1'b0, 2, a1);
`endif

    // LATENCY=1
    issue(1, 1'b1, 32'h40, 32'h01020304, 32'h0,        1'b0, st_lat(1), a1);
    issue(1, 1'b0, 32'h40, 32'h0,        32'h01020304, 1'b0, 1,         a1);
    issue(1, 1'b0, 32'h40, 32'h0,        32'h01020304, 1'b0, 1,         a2);
    chk(1, "b2b_gap_l1", 32'(a2 - a1), 32'd2);

    // LATENCY=8
    issue(2, 1'b1, 32'h40, 32'h0A0B0C0D, 32'h0,        1'b0, st_lat(2), a1);
    issue(2, 1'b0, 32'h40, 32'h0,        32'h0A0B0C0D, 1'b0, 8,         a1);
    issue(2, 1'b0, 32'h40, 32'h0,        32'h0A0B0C0D, 1'b0, 8,         a2);
    chk(2, "b2b_gap_l8", 32'(a2 - a1), 32'd9);
    issue(2, 1'b0, 32'h6,  32'h0,        32'h0,        1'b1, 8,         a1);

    idle(20);
    for (int d = 0; d < 3; d++) chk(d, "queue_empty", 32'(exp_q[d].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words in the data array (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to response (1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  CPU memory-stage request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_wr  input  1  1 = store (sw), 0 = load (lw).
REQ-008 SHALL have port req_adr  input  32  byte address (ALU result).
REQ-009 SHALL have port req_wdata  input  32  store data (busB).
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-011 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  output  1  access faulted; valid only with rsp_valid.

Function
REQ-013 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, capturing req_wr, req_adr and req_wdata.
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-015 SHALL transition IDLE->RESP on accept when LATENCY=1, otherwise IDLE->WAIT with a down-counter loaded to LATENCY-1.
REQ-016 SHALL decrement the counter each WAIT cycle and enter RESP when it reaches 1.
REQ-017 SHALL assert rsp_valid for exactly the one RESP cycle, i.e. LATENCY cycles after the accepting edge, then return to IDLE.
REQ-018 SHALL perform the array read or write on the edge entering RESP; a load SHALL return the word at index req_adr[log2(DEPTH)+1:2].
REQ-019 SHALL flag rsp_err=1 with no array write and rsp_rdata=0 when req_adr[1:0]!=0 or req_adr[31:2]>=DEPTH.
REQ-020 SHALL ignore req_valid while not in IDLE; the requester holds the request until req_ready is seen.
REQ-021 SHALL hold rsp_rdata and rsp_err at 0 whenever rsp_valid=0.

Reset
REQ-022 SHALL, on rst_n low at any time, including mid-transaction, force IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0, and abandon any pending access.
REQ-023 SHALL drive req_ready=1 from the first rising edge after rst_n deasserts; array contents SHALL NOT be reset.

Configuration
REQ-024 SHALL, with DMEM_WRBUF_EN defined, include a one-entry posted write buffer (address and data).
REQ-025 SHALL, with DMEM_WRBUF_EN defined, give a legal store to an empty buffer rsp_valid on the next cycle, independent of LATENCY.
REQ-026 SHALL, with DMEM_WRBUF_EN defined, drain the buffer to the array on the first IDLE cycle with no accepted request.
REQ-027 SHALL, with DMEM_WRBUF_EN defined, deassert req_ready to a store while the buffer is full.
REQ-028 SHALL, with DMEM_WRBUF_EN defined, return buffered data to a load matching the buffered address.
REQ-029 SHALL, without DMEM_WRBUF_EN, handle stores exactly as loads through the LATENCY path, with no buffer logic.

Structure
REQ-030 SHALL take the FSM state enum, the LATENCY and DEPTH default constants, and the address-check helper from shared package dmem_pkg.
REQ-031 SHALL instantiate exactly one sub-module, dmem_array, a single-port synchronous RAM of DEPTH x 32 bits.

Verification
REQ-032 Bench SHALL cover: LATENCY=2, sw adr 0x10 data 0xDEADBEEF then lw 0x10 -> rsp_valid two cycles after each accept, rdata 0xDEADBEEF.
REQ-033 Bench SHALL cover: lw adr 0x6 -> rsp_err=1, rdata 0; lw adr 0x400 with DEPTH=256 -> rsp_err=1.
REQ-034 Bench SHALL cover: back-to-back req_valid held high -> second accept only on the edge after RESP; req_ready=0 throughout WAIT and RESP.
REQ-035 Bench SHALL cover: rst_n pulled low in WAIT of sw 0x20 data 0x1234 -> no rsp_valid; a following lw 0x20 returns the prior contents.
REQ-036 Bench SHALL cover: DMEM_WRBUF_EN, sw 0x8 data 0xA5A5A5A5 then immediate lw 0x8 -> store rsp after 1 cycle, load returns 0xA5A5A5A5 via forwarding.
REQ-037 Bench SHALL cover: LATENCY=1 and LATENCY=8 -> response exactly 1 and 8 cycles after accept.
